// File: rtl/math_divider_seq.sv
// Sequential restoring divider: one quotient bit per clock, valid/ready on both sides.
// Define MATH_DIVIDER_SIGNED_EN for two's-complement operands (truncating toward zero).
module math_divider_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH:0]   partial_q;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             dbz_q;
   logic             out_valid_q;

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;
   logic             borrow;
   logic [WIDTH:0]   partial_d;
   logic [WIDTH-1:0] shift_d;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;

`ifdef MATH_DIVIDER_SIGNED_EN
   logic qneg_q;
   logic rneg_q;
`endif

   assign in_ready    = rst_n && (state_q == IDLE);
   assign out_valid   = out_valid_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

   // partial_q never exceeds divisor-1, so the shifted value fits WIDTH+1 bits;
   // the extra top bit of the subtraction is the borrow.
   always_comb begin
      shifted   = {partial_q, shift_q[WIDTH-1]};
      trial     = shifted - {2'b00, divisor_q};
      borrow    = trial[WIDTH+1];
      partial_d = borrow ? shifted[WIDTH:0] : trial[WIDTH:0];
      shift_d   = {shift_q[WIDTH-2:0], ~borrow};
`ifdef MATH_DIVIDER_SIGNED_EN
      a_mag = dividend[WIDTH-1] ? WIDTH'(-dividend) : dividend;
      b_mag = divisor[WIDTH-1]  ? WIDTH'(-divisor)  : divisor;
      q_fin = qneg_q ? WIDTH'(-shift_d) : shift_d;
      r_fin = rneg_q ? WIDTH'(-partial_d[WIDTH-1:0]) : partial_d[WIDTH-1:0];
`else
      a_mag = dividend;
      b_mag = divisor;
      q_fin = shift_d;
      r_fin = partial_d[WIDTH-1:0];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         divisor_q   <= '0;
         partial_q   <= '0;
         shift_q     <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef MATH_DIVIDER_SIGNED_EN
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (divisor == '0) begin
                     quotient_q  <= '1;
                     remainder_q <= dividend;
                     dbz_q       <= 1'b1;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     divisor_q <= b_mag;
                     partial_q <= '0;
                     shift_q   <= a_mag;
                     cnt_q     <= '0;
`ifdef MATH_DIVIDER_SIGNED_EN
                     qneg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                     rneg_q    <= dividend[WIDTH-1];
`endif
                     state_q   <= BUSY;
                  end
               end
            end
            BUSY: begin
               partial_q <= partial_d;
               shift_q   <= shift_d;
               cnt_q     <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  quotient_q  <= q_fin;
                  remainder_q <= r_fin;
                  dbz_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_math_divider_seq.sv
// Scoreboard bench for math_divider_seq (WIDTH=8); honours MATH_DIVIDER_SIGNED_EN.
module tb_math_divider_seq;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         in_ready, out_valid, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic rnd_bp  = 1'b0;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
   } exp_t;
   exp_t sb[$];

`ifdef MATH_DIVIDER_SIGNED_EN
   localparam logic [W-1:0] T_A = 8'hC8, T_B = 8'h07, T_Q = 8'hF8, T_R = 8'h00;  // -56/7
`else
   localparam logic [W-1:0] T_A = 8'd200, T_B = 8'd7, T_Q = 8'd28, T_R = 8'd4;
`endif

   always #5 clk = ~clk;

   math_divider_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
      z = 1'b0;
      if (b == '0) begin
         q = '1; r = a; z = 1'b1;
`ifdef MATH_DIVIDER_SIGNED_EN
      end else if (a == 8'h80 && b == 8'hFF) begin
         q = 8'h80; r = '0;
      end else begin
         q = W'($signed(a) / $signed(b));
         r = W'($signed(a) % $signed(b));
`else
      end else begin
         q = a / b;
         r = a % b;
`endif
      end
   endfunction

   // Monitor: a handshake completes at the next rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_result: got q=%0h r=%0h z=%0b, want none", quotient, remainder, div_by_zero);
         end else begin
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_by_zero", div_by_zero, e.z);
         end
      end
   end

   always @(posedge clk) begin
      if (rnd_bp) begin
         #2 out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Returns 1 ns after the accepting edge with in_valid dropped and operands scrambled.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
      exp_t e;
      int   guard;
      e.q = eq; e.r = er; e.z = ez;
      dividend = a; divisor = b; in_valid = 1'b1;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!in_ready && guard < 200);
      if (!in_ready) begin
         n_tests++; n_fail++;
         $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, want 1", guard);
      end else begin
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
   endtask

   task automatic drain();
      int g = 0;
      while (sb.size() != 0 && g < 500) begin
         @(posedge clk);
         g++;
      end
      #1;
      if (sb.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
      end
   endtask

   task automatic issue_model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] q, r;
      logic         z;
      model(a, b, q, r, z);
      issue(a, b, q, r, z);
   endtask

   initial begin
      logic [W-1:0] a, b;
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", in_ready, 1);

      // Latency, then backpressure for five cycles with an ignored in_valid pulse.
      out_ready = 1'b0;
      issue(T_A, T_B, T_Q, T_R, 1'b0);
      for (int i = 1; i <= W + 1; i++) begin
         @(negedge clk);
         if (i == W)     chk("lat_not_yet", out_valid, 0);
         if (i == W + 1) chk("lat_valid", out_valid, 1);
      end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         in_valid = (k == 2);
         dividend = 8'd9; divisor = 8'd3;
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_quotient", quotient, T_Q);
         chk("bp_remainder", remainder, T_R);
         chk("bp_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("hs_in_ready_low", in_ready, 0);
      @(negedge clk);
      chk("post_hs_in_ready", in_ready, 1);
      chk("post_hs_out_valid", out_valid, 0);
      chk("idle_hold_q", quotient, T_Q);
      @(posedge clk); #1;

      // Divide by zero: valid right after the accepting edge.
      out_ready = 1'b0;
      issue(8'd55, 8'd0, 8'hFF, 8'd55, 1'b1);
      @(negedge clk);
      chk("dbz_valid", out_valid, 1);
      chk("dbz_flag", div_by_zero, 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain();

      // Reset after three steps: result lost, everything back to zero.
      issue(T_A, T_B, T_Q, T_R, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      sb.delete();
      chk("abort_out_valid", out_valid, 0);
      chk("abort_quotient", quotient, 0);
      chk("abort_remainder", remainder, 0);
      chk("abort_dbz", div_by_zero, 0);
      chk("abort_in_ready", in_ready, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      issue(8'd100, 8'd10, 8'd10, 8'd0, 1'b0);
      drain();

      // Directed vectors, back to back.
`ifdef MATH_DIVIDER_SIGNED_EN
      issue(8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0);
      issue(8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0);
      issue(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
      issue(8'h80, 8'h01, 8'h80, 8'h00, 1'b0);
      issue(8'h7F, 8'hFF, 8'h81, 8'h00, 1'b0);
      issue(8'h05, 8'hF9, 8'h00, 8'h05, 1'b0);
      issue(8'h80, 8'h7F, 8'hFF, 8'hFF, 1'b0);
      issue(8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1);
`else
      issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
      issue(8'd5, 8'd200, 8'd0, 8'd5, 1'b0);
      issue(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
      issue(8'd254, 8'd255, 8'd0, 8'd254, 1'b0);
      issue(8'd0, 8'd3, 8'd0, 8'd0, 1'b0);
      issue(8'd128, 8'd16, 8'd8, 8'd0, 1'b0);
      issue(8'd37, 8'd6, 8'd6, 8'd1, 1'b0);
      issue(8'd17, 8'd0, 8'd255, 8'd17, 1'b1);
`endif
      drain();

      // Random pairs with random input gaps and output backpressure.
      rnd_bp = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         a = W'($urandom);
         b = W'($urandom);
         case ($urandom_range(0, 7))
            0: b = 8'd1;
            1: b = 8'd0;
            2: begin a = 8'hFF; b = 8'hFF; end
            3: b = a + 8'd1;
            4: a = 8'h80;
            default: ;
         endcase
         issue_model(a, b);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      rnd_bp = 1'b0;
      @(posedge clk); #3;
      out_ready = 1'b1;
      drain();
      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end
endmodule
